// File: rtl/idli_pkg.sv
// Shared constants and types for the SQI serial-SRAM responder.
// Optional feature macro: IDLI_SQI_MEM_MODE_REG_EN (adds WRMR/RDMR mode register).
package idli_pkg;

  localparam logic [7:0] SQI_OP_WRMR  = 8'h01;
  localparam logic [7:0] SQI_OP_WRITE = 8'h02;
  localparam logic [7:0] SQI_OP_READ  = 8'h03;
  localparam logic [7:0] SQI_OP_RDMR  = 8'h05;

  // Page-mode wrap size in bytes.
  localparam int unsigned SQI_PAGE_BYTES = 32;

  // Mode register value after reset: sequential.
  localparam logic [7:0] SQI_MODE_RESET = 8'h40;

  typedef enum logic [2:0] {
    SQI_IDLE,
    SQI_CMD,
    SQI_ADDR,
    SQI_DUMMY,
    SQI_RDATA,
    SQI_WDATA,
    SQI_IGNORE
  } sqi_mem_state_t;

  // Encoded as mode register bits [7:6].
  typedef enum logic [1:0] {
    SQI_MODE_BYTE     = 2'b00,
    SQI_MODE_SEQ      = 2'b01,
    SQI_MODE_PAGE     = 2'b10,
    SQI_MODE_SEQ_ALT  = 2'b11
  } sqi_mem_mode_t;

endpackage

// File: rtl/idli_sqi_mem_ram_m.sv
// DEPTH x 8 storage: one synchronous write port, one asynchronous read port.
module idli_sqi_mem_ram_m #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem_q [DEPTH];

  // Write port: byte lands on the clock edge where i_we is high.
  // NOTE: the array has no reset branch; clearing it would turn the RAM into flops.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: decodes opcode/address/dummy nibbles sampled on
// initiator SCK edges and serves byte writes and streamed reads over 4-bit SIO.
// Optional feature macro: IDLI_SQI_MEM_MODE_REG_EN (WRMR/RDMR mode register with
// byte/page/sequential addressing). Without it the device is always sequential.
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst,
  input  logic       i_mem_sck,
  input  logic       i_mem_cs,
  input  logic [3:0] i_mem_sio,
  output logic [3:0] o_mem_sio,
  output logic       o_mem_sio_oe
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PAGE_MASK =
    (DEPTH > SQI_PAGE_BYTES) ? AW'(SQI_PAGE_BYTES - 1) : '1;

  sqi_mem_state_t state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [11:0]    sr_q, sr_d;
  logic [7:0]     op_q, op_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           nib_q, nib_d;
  logic [3:0]     wbuf_q, wbuf_d;
  logic [3:0]     sio_q, sio_d;
  logic           oe_q, oe_d;
  logic           sck_q;

  logic           sck_rise, sck_fall;
  logic [7:0]     op_full;
  logic [15:0]    addr_full;
  logic [7:0]     wr_byte, rd_byte, ram_rdata;
  logic           ram_we;
  logic           is_rdmr, is_wrmr;
  logic           unused_addr;

  assign sck_rise    = i_mem_sck & ~sck_q;
  assign sck_fall    = ~i_mem_sck & sck_q;
  assign op_full     = {sr_q[3:0], i_mem_sio};
  assign addr_full   = {sr_q, i_mem_sio};
  assign wr_byte     = {wbuf_q, i_mem_sio};
  // Bits above the storage size are accepted on the wire and dropped.
  assign unused_addr = ^addr_full;

`ifdef IDLI_SQI_MEM_MODE_REG_EN
  logic [7:0]    mode_q, mode_d;
  sqi_mem_mode_t cur_mode;
  assign cur_mode = sqi_mem_mode_t'(mode_q[7:6]);
  assign is_rdmr  = (op_q == SQI_OP_RDMR);
  assign is_wrmr  = (op_q == SQI_OP_WRMR);
  assign rd_byte  = is_rdmr ? mode_q : ram_rdata;
`else
  localparam sqi_mem_mode_t cur_mode = SQI_MODE_SEQ;
  assign is_rdmr = 1'b0;
  assign is_wrmr = 1'b0;
  assign rd_byte = ram_rdata;
`endif

  // Address after one byte, honouring byte (hold), page (32-byte wrap) or sequential mode.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input sqi_mem_mode_t m);
    logic [AW-1:0] inc;
    inc = a + AW'(1);
    case (m)
      SQI_MODE_BYTE: return a;
      SQI_MODE_PAGE: return (a & ~PAGE_MASK) | (inc & PAGE_MASK);
      default:       return inc;
    endcase
  endfunction

  idli_sqi_mem_ram_m #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk   (i_mem_gck),
    .i_we    (ram_we),
    .i_waddr (addr_q),
    .i_wdata (wr_byte),
    .i_raddr (addr_q),
    .o_rdata (ram_rdata)
  );

  // State, datapath and output registers; storage itself is never reset.
  // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
  always_ff @(posedge i_mem_gck or posedge i_mem_rst) begin
    if (i_mem_rst) begin
      state_q <= SQI_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      nib_q   <= 1'b0;
      wbuf_q  <= '0;
      sio_q   <= '0;
      oe_q    <= 1'b0;
      sck_q   <= 1'b0;
`ifdef IDLI_SQI_MEM_MODE_REG_EN
      mode_q  <= SQI_MODE_RESET;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      nib_q   <= nib_d;
      wbuf_q  <= wbuf_d;
      sio_q   <= sio_d;
      oe_q    <= oe_d;
      sck_q   <= i_mem_sck;
`ifdef IDLI_SQI_MEM_MODE_REG_EN
      mode_q  <= mode_d;
`endif
    end
  end

  // Next-state and datapath decode, driven by detected SCK edges while CS is low.
  // NOTE: every output is given its hold value first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    op_d    = op_q;
    addr_d  = addr_q;
    nib_d   = nib_q;
    wbuf_d  = wbuf_q;
    sio_d   = sio_q;
    oe_d    = oe_q;
    ram_we  = 1'b0;
`ifdef IDLI_SQI_MEM_MODE_REG_EN
    mode_d  = mode_q;
`endif
    if (i_mem_cs) begin
      // Deselect: drop any half-byte of write data and release the bus.
      state_d = SQI_IDLE;
      cnt_d   = '0;
      nib_d   = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        // IDLE behaves as CMD so a rise coincident with CS falling is the first nibble.
        SQI_IDLE, SQI_CMD: begin
          state_d = SQI_CMD;
          if (sck_rise) begin
            sr_d = {sr_q[7:0], i_mem_sio};
            if (cnt_q == 2'd0) begin
              cnt_d = 2'd1;
            end else begin
              op_d  = op_full;
              cnt_d = '0;
              nib_d = 1'b0;
              case (op_full)
                SQI_OP_READ, SQI_OP_WRITE: state_d = SQI_ADDR;
`ifdef IDLI_SQI_MEM_MODE_REG_EN
                SQI_OP_WRMR:               state_d = SQI_WDATA;
                SQI_OP_RDMR:               state_d = SQI_RDATA;
`endif
                default:                   state_d = SQI_IGNORE;
              endcase
            end
          end
        end
        SQI_ADDR: begin
          if (sck_rise) begin
            sr_d  = {sr_q[7:0], i_mem_sio};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              addr_d  = addr_full[AW-1:0];
              state_d = (op_q == SQI_OP_READ) ? SQI_DUMMY : SQI_WDATA;
            end
          end
        end
        SQI_DUMMY: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd1) begin
              cnt_d   = '0;
              state_d = SQI_RDATA;
            end
          end
        end
        SQI_RDATA: begin
          if (sck_fall) begin
            oe_d  = 1'b1;
            sio_d = nib_q ? rd_byte[3:0] : rd_byte[7:4];
            nib_d = ~nib_q;
            if (nib_q && !is_rdmr) begin
              addr_d = next_addr(addr_q, cur_mode);
            end
          end
        end
        SQI_WDATA: begin
          if (sck_rise) begin
            if (!nib_q) begin
              wbuf_d = i_mem_sio;
              nib_d  = 1'b1;
            end else if (is_wrmr) begin
              nib_d   = 1'b0;
              state_d = SQI_IGNORE;
`ifdef IDLI_SQI_MEM_MODE_REG_EN
              mode_d  = wr_byte;
`endif
            end else begin
              nib_d  = 1'b0;
              ram_we = 1'b1;
              addr_d = next_addr(addr_q, cur_mode);
              if (cur_mode == SQI_MODE_BYTE) begin
                state_d = SQI_IGNORE;
              end
            end
          end
        end
        SQI_IGNORE: begin
          state_d = SQI_IGNORE;
        end
        default: begin
          state_d = SQI_IDLE;
        end
      endcase
    end
  end

  assign o_mem_sio    = sio_q;
  assign o_mem_sio_oe = oe_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Self-checking bench for idli_sqi_mem_m: transaction-level byte-array model,
// per-cycle output compare, literal pins on directed scenarios, random traffic.
// Honours IDLI_SQI_MEM_MODE_REG_EN when the design is built with it.
module tb_idli_sqi_mem_m;

  localparam int DEPTH = 256;
  localparam int PH    = 3;   // gck per SCK phase

  logic       gck = 1'b0;
  logic       rst;
  logic       sck;
  logic       cs;
  logic [3:0] sio_drv;
  logic [3:0] sio_o;
  logic       oe_o;

  idli_sqi_mem_m #(.DEPTH(DEPTH)) dut (
    .i_mem_gck    (gck),
    .i_mem_rst    (rst),
    .i_mem_sck    (sck),
    .i_mem_cs     (cs),
    .i_mem_sio    (sio_drv),
    .o_mem_sio    (sio_o),
    .o_mem_sio_oe (oe_o)
  );

  always #5 gck = ~gck;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected bus state, advanced by the driver right after the DUT should update.
  logic       exp_oe  = 1'b0;
  logic [3:0] exp_sio = 4'h0;
  bit         cmp_en  = 1'b0;

  // Behavioural model: plain byte array plus mode byte.
  logic [7:0] mem_m [DEPTH];
  logic [7:0] mode_m = 8'h40;

  logic [3:0] tx_q [$];
  logic [3:0] exp_q [$];
  logic [3:0] rx_q [$];
  logic [7:0] wq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge gck);
    #1;
  endtask

  // Every cycle the outputs are meaningful: oe always, sio whenever it is driven.
  always @(negedge gck) begin
    if (cmp_en) begin
      check("oe_cycle", oe_o, exp_oe);
      if (exp_oe) check("sio_cycle", sio_o, exp_sio);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Address after one byte under the current mode.
  function automatic int m_next(input int a);
    case (mode_m[7:6])
      2'b00:   return a;
      2'b10:   return (a / 32) * 32 + (a + 1) % 32;
      default: return (a + 1) % DEPTH;
    endcase
  endfunction

  // One CS-low transaction: cycle j sends tx_q[j] on its rise; the fall ending
  // cycle rd_start+k presents exp_q[k]. rst_at >= 0 resets at that cycle instead.
  task automatic run_txn(input bit same_edge, input int rd_start, input int rst_at);
    int total;
    total = tx_q.size();
    if (exp_q.size() > 0 && rd_start + exp_q.size() > total) total = rd_start + exp_q.size();
    rx_q.delete();
    for (int j = 0; j < total; j++) begin
      bit rd;
      if (j == rst_at) begin
        rst = 1'b1; cs = 1'b1; sck = 1'b0;
        exp_oe = 1'b0; exp_sio = 4'h0;
        #1;
        check("rst_mid_oe", oe_o, 1'b0);
        check("rst_mid_sio", sio_o, 4'h0);
        tick(3);
        rst = 1'b0;
        tick(2);
        return;
      end
      rd = exp_q.size() > 0 && j >= rd_start && (j - rd_start) < exp_q.size();
      sio_drv = (j < tx_q.size()) ? tx_q[j] : 4'($urandom);
      if (j == 0) begin
        cs = 1'b0;
        if (!same_edge) tick(PH);
      end else begin
        tick(PH - 1);
      end
      sck = 1'b1;
      tick(PH);
      sck = 1'b0;
      tick(1);
      if (rd) begin
        exp_oe  = 1'b1;
        exp_sio = exp_q[j - rd_start];
        rx_q.push_back(sio_o);
      end
    end
    tick(1);
    cs = 1'b1;
    tick(1);
    exp_oe = 1'b0;
    tick(PH);
  endtask

  task automatic push_addr(input int addr);
    for (int s = 12; s >= 0; s -= 4) tx_q.push_back(4'(addr >> s));
  endtask

  // WRITE of wq at addr; extra appends a dangling half byte.
  task automatic do_write(input int addr, input bit extra, input bit same_edge);
    int a;
    tx_q = {4'h0, 4'h2};
    push_addr(addr);
    foreach (wq[i]) begin
      tx_q.push_back(wq[i][7:4]);
      tx_q.push_back(wq[i][3:0]);
    end
    if (extra) tx_q.push_back(4'($urandom));
    exp_q.delete();
    run_txn(same_edge, 1000, -1);
    a = addr % DEPTH;
    foreach (wq[i]) begin
      if (mode_m[7:6] == 2'b00 && i > 0) break;
      mem_m[a] = wq[i];
      a = m_next(a);
    end
  endtask

  task automatic build_read(input int addr, input int n);
    int a;
    tx_q = {4'h0, 4'h3};
    push_addr(addr);
    tx_q.push_back(4'($urandom));
    tx_q.push_back(4'($urandom));
    exp_q.delete();
    a = addr % DEPTH;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem_m[a][7:4]);
      exp_q.push_back(mem_m[a][3:0]);
      a = m_next(a);
    end
  endtask

  task automatic do_read(input int addr, input int n, input bit same_edge);
    build_read(addr, n);
    run_txn(same_edge, 7, -1);
    check("rd_len", rx_q.size(), 2 * n);
  endtask

  task automatic do_wrmr(input logic [7:0] v);
    tx_q = {4'h0, 4'h1, v[7:4], v[3:0]};
    exp_q.delete();
    run_txn(1'b0, 1000, -1);
`ifdef IDLI_SQI_MEM_MODE_REG_EN
    mode_m = v;
`endif
  endtask

  task automatic do_rdmr(input int n_nib);
    tx_q = {4'h0, 4'h5};
    exp_q.delete();
`ifdef IDLI_SQI_MEM_MODE_REG_EN
    for (int i = 0; i < n_nib; i++) exp_q.push_back(i % 2 == 0 ? mode_m[7:4] : mode_m[3:0]);
`else
    n_nib = 0;
`endif
    if (exp_q.size() == 0) begin
      tx_q.push_back(4'h0);
      tx_q.push_back(4'h0);
    end
    run_txn(1'b0, 1, -1);
  endtask

  initial begin
    logic [7:0] old21;
    rst = 1'b1; cs = 1'b1; sck = 1'b0; sio_drv = 4'h0;
    tick(3);
    check("reset_oe", oe_o, 1'b0);
    check("reset_sio", sio_o, 4'h0);
    rst = 1'b0;
    tick(2);
    cmp_en = 1'b1;

    // Fill all storage so every later read has a known model value.
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(8'($urandom));
    do_write(0, 1'b0, 1'b0);

    // Basic write then read back, pinned by literals.
    wq = {8'hA5, 8'h3C};
    do_write(16'h0010, 1'b0, 1'b0);
    do_read(16'h0010, 2, 1'b0);
    check("lit_a5_hi", rx_q[0], 4'hA);
    check("lit_a5_lo", rx_q[1], 4'h5);
    check("lit_3c_hi", rx_q[2], 4'h3);
    check("lit_3c_lo", rx_q[3], 4'hC);

    // Wrap at DEPTH with junk in the upper address byte.
    wq = {8'h11, 8'h22};
    do_write(16'hABFF, 1'b0, 1'b0);
    do_read(16'h00FF, 2, 1'b0);
    check("lit_wrap_ff", {rx_q[0], rx_q[1]}, 8'h11);
    check("lit_wrap_00", {rx_q[2], rx_q[3]}, 8'h22);

    // Dangling half byte is discarded.
    old21 = mem_m[8'h21];
    wq = {8'h5A};
    do_write(16'h0020, 1'b1, 1'b0);
    do_read(16'h0020, 2, 1'b0);
    check("lit_part_20", {rx_q[0], rx_q[1]}, 8'h5A);
    check("part_21_kept", {rx_q[2], rx_q[3]}, old21);

    // Unknown opcode: bus stays released, nothing written.
    tx_q = {4'h9, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    exp_q.delete();
    run_txn(1'b0, 1000, -1);
    do_read(16'h0010, 2, 1'b0);
    check("lit_9f_nowr", {rx_q[0], rx_q[1], rx_q[2], rx_q[3]}, 16'hA53C);

    // Reset in the middle of RDATA, then a clean read.
    build_read(16'h0080, 4);
    run_txn(1'b0, 7, 10);
    do_read(16'h0010, 1, 1'b0);
    check("lit_after_rst", {rx_q[0], rx_q[1]}, 8'hA5);

    // CS falling in the same gck as the first SCK rise.
    wq = {8'hC3};
    do_write(16'h0040, 1'b0, 1'b1);
    do_read(16'h0040, 1, 1'b1);
    check("lit_same_edge", {rx_q[0], rx_q[1]}, 8'hC3);

    // Mode register: page mode wraps inside 32 bytes; absent build stays sequential.
    do_wrmr(8'h80);
    wq = {8'h01, 8'h02};
    do_write(16'h001F, 1'b0, 1'b0);
    do_read(16'h001F, 1, 1'b0);
    check("lit_pg_1f", {rx_q[0], rx_q[1]}, 8'h01);
`ifdef IDLI_SQI_MEM_MODE_REG_EN
    do_read(16'h0000, 1, 1'b0);
`else
    do_read(16'h0020, 1, 1'b0);
`endif
    check("lit_pg_next", {rx_q[0], rx_q[1]}, 8'h02);
    do_rdmr(4);
`ifdef IDLI_SQI_MEM_MODE_REG_EN
    check("lit_rdmr", {rx_q[0], rx_q[1], rx_q[2], rx_q[3]}, 16'h8080);
`else
    check("rdmr_absent", rx_q.size(), 0);
`endif
    do_wrmr(8'h40);

    // Random traffic against the model.
    for (int t = 0; t < 40; t++) begin
      int addr, len;
      addr = int'($urandom_range(0, 65535));
      len  = int'($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
        do_write(addr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        do_read(addr, len, 1'($urandom_range(0, 1)));
      end
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/idli_sqi_mem_m.md
# idli_sqi_mem_m

Synthesizable SQI serial-SRAM responder: the memory-device end of the core's quad-SPI memory bus. Decodes instruction, address and dummy nibbles clocked in on an initiator-driven SCK, then stores write data into an internal byte array or streams read data back on the shared 4-bit SIO bus. Serves as the simulation and FPGA stand-in for the external SRAM attached to the core's memory pins.

## Interface
- DEPTH, 256, bytes of storage; power of two, 2..65536; wire address is always 16 bits, upper bits ignored.
- i_mem_gck  in  1  system clock; all logic on rising edge.
- i_mem_rst  in  1  reset, asynchronous, active-high.
- i_mem_sck  in  1  serial clock from initiator, synchronous to i_mem_gck.
- i_mem_cs  in  1  chip select, active-low.
- i_mem_sio  in  4  nibble from initiator.
- o_mem_sio  out  4  nibble to initiator.
- o_mem_sio_oe  out  1  high while responder drives SIO.

## Operation
- Edge detect: sck_q registered each gck; rise = sck & ~sck_q, fall = ~sck & sck_q. SCK high and low phases are each ≥2 gck.
- Initiator changes SIO after SCK falling; responder samples i_mem_sio on rise.
- Nibble order most-significant first for opcode, address and data bytes.
- States: IDLE, CMD (2 nibbles), ADDR (4 nibbles), DUMMY (2 nibbles, reads only), RDATA, WDATA, IGNORE.
- CS falling enters CMD with nibble count 0. Opcodes: 0x03 READ → ADDR → DUMMY → RDATA; 0x02 WRITE → ADDR → WDATA; any other → IGNORE until CS high.
- WDATA: high nibble held; on rise of low nibble, mem[addr] written, addr increments.
- RDATA: on each fall, o_mem_sio = next nibble of mem[addr] (high, then low); addr increments after the low nibble is presented. First high nibble is driven on the fall following the final dummy rise.
- Address increments modulo DEPTH (DEPTH-1 → 0).
- CS high at any point: state → IDLE, o_mem_sio_oe → 0, a held half-byte of write data is discarded (no write), addr unchanged but irrelevant.
- SCK edges while CS high are ignored. CS falling and SCK rising in the same gck: the edge is treated as the first CMD nibble sample.

## Timing
- Reset values: o_mem_sio = 0, o_mem_sio_oe = 0, state IDLE, sck_q = 0, mode register = sequential. Storage is not reset.
- o_mem_sio and o_mem_sio_oe are registered; they update 1 gck after the detected fall (2 gck after SCK pin falls).
- o_mem_sio_oe asserts with the first read nibble and stays high until the gck after CS rises.
- Write lands in storage 1 gck after the detected rise of the low nibble; same-transaction readback requires a new READ.
- Reset mid-transaction aborts immediately; no partial write.

## Configuration
- IDLI_SQI_MEM_MODE_REG_EN defined: 8-bit mode register; opcode 0x01 WRMR (2 data nibbles, then IGNORE), 0x05 RDMR (drives register on following falls, repeating). Bits [7:6]: 00 byte (one byte per transaction; further write data ignored, reads repeat same byte), 10 page (address wraps within 32-byte page), 01/11 sequential. Reset value 0x40.
- Not defined: no register; 0x01/0x05 go to IGNORE; always sequential.

## Structure
- idli_pkg: opcode constants (SQI_OP_READ, SQI_OP_WRITE, SQI_OP_WRMR, SQI_OP_RDMR), state enum sqi_mem_state_t, mode enum sqi_mem_mode_t, page size constant.
- Sub-module idli_sqi_mem_ram_m: DEPTH×8 array, one synchronous write port, one asynchronous read port.

## Test plan
- Reset asserted mid-RDATA → o_mem_sio_oe = 0, o_mem_sio = 0 within 1 gck; next READ works normally.
- WRITE 0x0010 bytes A5 3C, CS high, READ 0x0010 → dummy, then nibbles A,5,3,C; oe high from first nibble until CS high.
- DEPTH=256, WRITE 0x00FF bytes 11 22 → mem[0xFF]=0x11, mem[0x00]=0x22 (wrap); upper address byte ignored.
- WRITE 0x0020 sending 3 data nibbles then CS high → only mem[0x20] updated; mem[0x21] unchanged.
- Opcode 0x9F → no write, oe stays 0 for entire transaction.
- With IDLI_SQI_MEM_MODE_REG_EN: WRMR 0x80, WRITE 0x001F bytes 01 02 → mem[0x1F]=0x01, mem[0x00]=0x02; RDMR returns 0x80. Without the macro: same sequence leaves register absent and WRITE wraps at DEPTH only.
